// File: rtl/pe_ctx_sequencer_pkg.sv
// Shared types and constants for the PE context sequencer.
// Optional feature macro: PE_CTX_PARITY_EN (per-word even parity in the context store).
package pe_ctx_sequencer_pkg;

  localparam int unsigned NUM_PE      = 4;
  localparam int unsigned NUM_CTX     = 8;
  localparam int unsigned CW_W        = 8;
  localparam int unsigned CTX_W       = $clog2(NUM_CTX);
  localparam int unsigned PE_W        = $clog2(NUM_PE);
  localparam int unsigned LOOP_W      = 4;
  localparam int unsigned SEL_W       = 3;
  localparam int unsigned ALU_W       = 2;
  localparam int unsigned DRAIN_DEPTH = 2;
  localparam int unsigned DRAIN_W     = $clog2(DRAIN_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Control word as seen by a PE: sel_op_0[7:5], sel_op_1[4:2], alu_op[1:0]
  typedef struct packed {
    logic [SEL_W-1:0] sel_op_0;
    logic [SEL_W-1:0] sel_op_1;
    logic [ALU_W-1:0] alu_op;
  } ctrl_word_t;

  localparam logic [ALU_W-1:0] ALU_OR  = 2'd0;
  localparam logic [ALU_W-1:0] ALU_AND = 2'd1;
  localparam logic [ALU_W-1:0] ALU_XOR = 2'd2;
  localparam logic [ALU_W-1:0] ALU_SLL = 2'd3;

  function automatic logic even_parity(input ctrl_word_t w);
    return ^w;
  endfunction

endpackage

// File: rtl/pe_ctx_sequencer_if.sv
// Host/PE-side bus of the context sequencer; slave modport is the sequencer.
// Optional feature macro: PE_CTX_PARITY_EN adds par_err.
interface pe_ctx_sequencer_if
  import pe_ctx_sequencer_pkg::*;
();
  logic                     cfg_we;
  logic [CTX_W-1:0]         cfg_ctx;
  logic [PE_W-1:0]          cfg_pe;
  logic [CW_W-1:0]          cfg_data;
  logic                     cfg_err;
  logic                     start;
  logic [CTX_W-1:0]         last_ctx;
  logic [LOOP_W-1:0]        loop_cnt;
  logic                     stall;
  logic [NUM_PE*CW_W-1:0]   ctr_signals_out;
  logic                     pe_en;
  logic [CTX_W-1:0]         ctx_idx;
  logic                     busy;
  logic                     done;
`ifdef PE_CTX_PARITY_EN
  logic                     par_err;
`endif

  modport master (
    output cfg_we, cfg_ctx, cfg_pe, cfg_data, start, last_ctx, loop_cnt, stall,
    input  cfg_err, ctr_signals_out, pe_en, ctx_idx, busy, done
`ifdef PE_CTX_PARITY_EN
    , input par_err
`endif
  );

  modport slave (
    input  cfg_we, cfg_ctx, cfg_pe, cfg_data, start, last_ctx, loop_cnt, stall,
    output cfg_err, ctr_signals_out, pe_en, ctx_idx, busy, done
`ifdef PE_CTX_PARITY_EN
    , output par_err
`endif
  );

endinterface

// File: rtl/pe_ctx_store.sv
// NUM_CTX x NUM_PE control-word memory: one word write port, one whole-context read port.
// Optional feature macro: PE_CTX_PARITY_EN stores and checks one even-parity bit per word.
module pe_ctx_store
  import pe_ctx_sequencer_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [CTX_W-1:0]         wr_ctx_i,
  input  logic [PE_W-1:0]          wr_pe_i,
  input  ctrl_word_t               wr_data_i,
  input  logic [CTX_W-1:0]         rd_ctx_i,
  output ctrl_word_t [NUM_PE-1:0]  rd_data_o
`ifdef PE_CTX_PARITY_EN
  , output logic                   rd_par_err_o
`endif
);

  // Deliberately unreset so contents survive a sequencer reset
  ctrl_word_t [NUM_PE-1:0] mem_q [NUM_CTX];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[wr_ctx_i][wr_pe_i] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ctx_i];

`ifdef PE_CTX_PARITY_EN
  logic [NUM_PE-1:0] par_q [NUM_CTX];
  logic [NUM_PE-1:0] par_rd_c;

  always_ff @(posedge clk_i) begin
    if (we_i) par_q[wr_ctx_i][wr_pe_i] <= even_parity(wr_data_i);
  end

  always_comb begin
    par_rd_c = par_q[rd_ctx_i];
    rd_par_err_o = 1'b0;
    for (int p = 0; p < int'(NUM_PE); p++) begin
      if (even_parity(rd_data_o[p]) != par_rd_c[p]) rd_par_err_o = 1'b1;
    end
  end
`endif

endmodule

// File: rtl/pe_ctx_sequencer.sv
// Replays stored contexts 0..last_ctx to all PEs (loop_cnt extra passes), drains, then pulses done.
// Optional feature macro: PE_CTX_PARITY_EN aborts a run on a store parity error.
module pe_ctx_sequencer
  import pe_ctx_sequencer_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  pe_ctx_sequencer_if.slave  bus
);

  state_e                   state_q, state_d;
  logic [CTX_W-1:0]         ctx_idx_q, ctx_idx_d;
  logic [CTX_W-1:0]         last_q, last_d;
  logic [LOOP_W-1:0]        loop_q, loop_d;
  logic [DRAIN_W-1:0]       drain_q, drain_d;
  ctrl_word_t [NUM_PE-1:0]  ctrl_q, ctrl_d;
  ctrl_word_t [NUM_PE-1:0]  rd_data_c;
  logic [CTX_W-1:0]         rd_ctx_c;
  logic                     pe_en_q, pe_en_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     cfg_err_q, cfg_err_d;
  logic                     wr_en_c;
  logic                     load_c;
`ifdef PE_CTX_PARITY_EN
  logic                     par_bad_c;
  logic                     par_err_q, par_err_d;
`endif

  assign wr_en_c = bus.cfg_we && !bus.start && (state_q == ST_IDLE);

  pe_ctx_store u_store (
    .clk_i     (clock),
    .we_i      (wr_en_c),
    .wr_ctx_i  (bus.cfg_ctx),
    .wr_pe_i   (bus.cfg_pe),
    .wr_data_i (ctrl_word_t'(bus.cfg_data)),
    .rd_ctx_i  (rd_ctx_c),
    .rd_data_o (rd_data_c)
`ifdef PE_CTX_PARITY_EN
    , .rd_par_err_o (par_bad_c)
`endif
  );

  // Next context to present: successor while below last_ctx, otherwise context 0
  always_comb begin
    rd_ctx_c = '0;
    if ((state_q == ST_RUN) && (ctx_idx_q < last_q)) rd_ctx_c = ctx_idx_q + CTX_W'(1);
  end

  always_comb begin
    state_d   = state_q;
    ctx_idx_d = ctx_idx_q;
    last_d    = last_q;
    loop_d    = loop_q;
    drain_d   = drain_q;
    ctrl_d    = ctrl_q;
    pe_en_d   = pe_en_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    cfg_err_d = bus.cfg_we && (bus.start || (state_q != ST_IDLE));
    load_c    = 1'b0;
`ifdef PE_CTX_PARITY_EN
    par_err_d = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          last_d    = bus.last_ctx;
          loop_d    = bus.loop_cnt;
          ctx_idx_d = '0;
          ctrl_d    = rd_data_c;
          pe_en_d   = 1'b1;
          busy_d    = 1'b1;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!bus.stall) begin
          if (ctx_idx_q < last_q) begin
            ctx_idx_d = rd_ctx_c;
            load_c    = 1'b1;
          end else if (loop_q != '0) begin
            loop_d    = loop_q - LOOP_W'(1);
            ctx_idx_d = '0;
            load_c    = 1'b1;
          end else begin
            drain_d = DRAIN_W'(DRAIN_DEPTH);
            state_d = ST_DRAIN;
          end
          if (load_c) ctrl_d = rd_data_c;
`ifdef PE_CTX_PARITY_EN
          // Corrupt context: abandon the run without presenting it
          if (load_c && par_bad_c) begin
            ctx_idx_d = ctx_idx_q;
            ctrl_d    = ctrl_q;
            pe_en_d   = 1'b0;
            busy_d    = 1'b0;
            par_err_d = 1'b1;
            state_d   = ST_IDLE;
          end
`endif
        end
      end
      ST_DRAIN: begin
        if (!bus.stall) begin
          if (drain_q == DRAIN_W'(1)) begin
            pe_en_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            drain_d = drain_q - DRAIN_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ctx_idx_q <= '0;
      last_q    <= '0;
      loop_q    <= '0;
      drain_q   <= '0;
      ctrl_q    <= '0;
      pe_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
`ifdef PE_CTX_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ctx_idx_q <= ctx_idx_d;
      last_q    <= last_d;
      loop_q    <= loop_d;
      drain_q   <= drain_d;
      ctrl_q    <= ctrl_d;
      pe_en_q   <= pe_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cfg_err_q <= cfg_err_d;
`ifdef PE_CTX_PARITY_EN
      par_err_q <= par_err_d;
`endif
    end
  end

  // Stall gates the enable immediately; the registered value resumes after it
  assign bus.pe_en           = pe_en_q && !bus.stall;
  assign bus.ctr_signals_out = ctrl_q;
  assign bus.ctx_idx         = ctx_idx_q;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.cfg_err         = cfg_err_q;
`ifdef PE_CTX_PARITY_EN
  assign bus.par_err         = par_err_q;
`endif

endmodule
